// File: rtl/mem_access_ctrl_if.sv
// Bundles the pipeline request/response signals and the byte-wide memory port of mem_access_ctrl.
// slave = the controller side, master = the pipeline/memory environment driving it.
interface mem_access_ctrl_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
);
   logic              req_i;
   logic              we_i;
   logic [1:0]        sel_i;
   logic              sign_i;
   logic [ADDR_W-1:0] addr_i;
   logic [XLEN-1:0]   wdata_i;
   logic [ADDR_W-1:0] ram_addr_o;
   logic              ram_we_o;
   logic [7:0]        ram_wdata_o;
   logic [7:0]        ram_rdata_i;
   logic              busy_o;
   logic              done_o;
   logic              err_o;
   logic [XLEN-1:0]   rdata_o;

   modport slave (
      input  req_i, we_i, sel_i, sign_i, addr_i, wdata_i, ram_rdata_i,
      output ram_addr_o, ram_we_o, ram_wdata_o, busy_o, done_o, err_o, rdata_o
   );

   modport master (
      output req_i, we_i, sel_i, sign_i, addr_i, wdata_i, ram_rdata_i,
      input  ram_addr_o, ram_we_o, ram_wdata_o, busy_o, done_o, err_o, rdata_o
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Serialises byte/half/word/double loads and stores onto a byte-wide memory port with a
// fixed read latency, assembling and sign/zero-extending load results.
module mem_access_ctrl #(
   parameter int XLEN        = 32,
   parameter int ADDR_W      = 32,
   parameter int RD_LAT      = 2,
   parameter int ALIGN_CHECK = 1
) (
   input  logic             clk,
   input  logic             rst,
   mem_access_ctrl_if.slave bus
);

   typedef enum logic [2:0] {S_IDLE, S_STORE, S_LOAD, S_DRAIN, S_FIN} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [ADDR_W-1:0]   r_base;
   logic [3:0]          r_nbytes;
   logic                r_sign;
   logic [XLEN-1:0]     r_wdata;
   logic                r_err;
   logic [3:0]          r_cnt;
   logic [3:0]          r_rcnt;
   logic [RD_LAT-1:0]   r_rpipe;
   logic [XLEN-1:0]     r_rbuf;
   logic [XLEN-1:0]     r_rdata;

   logic                w_accept;
   logic [3:0]          w_nbytes;
   logic [2:0]          w_amask;
   logic                w_illegal;
   logic                w_issue_last;
   logic                w_cap;
   logic                w_cap_last;
   logic [5:0]          w_wsh;
   logic [5:0]          w_rsh;
   logic [XLEN-1:0]     w_assembled;

   function automatic logic [XLEN-1:0] f_extend(input logic [XLEN-1:0] v,
                                                input logic [3:0]      n,
                                                input logic            s);
      logic [XLEN-1:0] keep;
      logic            fill;
      case (n)
         4'd1:    begin keep = XLEN'(8'hFF);         fill = v[7];  end
         4'd2:    begin keep = XLEN'(16'hFFFF);      fill = v[15]; end
         4'd4:    begin keep = XLEN'(32'hFFFF_FFFF); fill = v[31]; end
         default: begin keep = '1;                   fill = 1'b0;  end
      endcase
      return (v & keep) | ({XLEN{s & fill}} & ~keep);
   endfunction

   always_comb begin
      case (bus.sel_i)
         2'b00:   w_nbytes = 4'd1;
         2'b01:   w_nbytes = 4'd2;
         2'b10:   w_nbytes = 4'd4;
         default: w_nbytes = 4'd8;
      endcase
   end

   assign w_accept     = (r_state == S_IDLE) && bus.req_i;
   assign w_amask      = w_nbytes[2:0] - 3'd1;
   assign w_illegal    = ((bus.sel_i == 2'b11) && (XLEN == 32)) ||
                         ((ALIGN_CHECK != 0) && ((bus.addr_i[2:0] & w_amask) != 3'd0));
   assign w_issue_last = (r_cnt == r_nbytes - 4'd1);
   // A byte is on ram_rdata_i when the address issued RD_LAT cycles earlier reaches the pipe end.
   assign w_cap        = r_rpipe[RD_LAT-1];
   assign w_cap_last   = w_cap && (r_rcnt == r_nbytes - 4'd1);
   assign w_wsh        = {r_cnt[2:0], 3'b000};
   assign w_rsh        = {r_rcnt[2:0], 3'b000};
   assign w_assembled  = (r_rbuf & ~(XLEN'(8'hFF) << w_rsh)) | (XLEN'(bus.ram_rdata_i) << w_rsh);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.req_i) begin
               if (w_illegal)      w_next = S_FIN;
               else if (bus.we_i)  w_next = S_STORE;
               else                w_next = S_LOAD;
            end
         end
         S_STORE: if (w_issue_last) w_next = S_FIN;
         S_LOAD:  if (w_issue_last) w_next = S_DRAIN;
         S_DRAIN: if (w_cap_last)   w_next = S_FIN;
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.ram_we_o    = 1'b0;
      bus.ram_addr_o  = '0;
      bus.ram_wdata_o = 8'h00;
      if (r_state == S_STORE) begin
         bus.ram_we_o    = 1'b1;
         bus.ram_addr_o  = r_base + ADDR_W'(r_cnt);
         bus.ram_wdata_o = 8'(r_wdata >> w_wsh);
      end else if (r_state == S_LOAD) begin
         bus.ram_addr_o  = r_base + ADDR_W'(r_cnt);
      end
   end

   // busy is gated by rst so a request held during reset cannot stall the pipeline.
   assign bus.busy_o  = rst && (w_accept || (r_state == S_STORE) ||
                                (r_state == S_LOAD) || (r_state == S_DRAIN));
   assign bus.done_o  = (r_state == S_FIN);
   assign bus.err_o   = (r_state == S_FIN) && r_err;
   assign bus.rdata_o = r_rdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_err   <= 1'b0;
         r_cnt   <= 4'd0;
         r_rcnt  <= 4'd0;
         r_rpipe <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= w_next;
         r_rpipe <= (r_rpipe << 1) | RD_LAT'(r_state == S_LOAD);
         if (w_accept) begin
            r_err  <= w_illegal;
            r_cnt  <= 4'd0;
            r_rcnt <= 4'd0;
         end else if ((r_state == S_STORE) || (r_state == S_LOAD)) begin
            r_cnt  <= r_cnt + 4'd1;
         end
         if (w_cap) begin
            r_rcnt <= r_rcnt + 4'd1;
            if (w_cap_last) r_rdata <= f_extend(w_assembled, r_nbytes, r_sign);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_base   <= bus.addr_i;
         r_nbytes <= w_nbytes;
         r_sign   <= bus.sign_i;
         r_wdata  <= bus.wdata_i;
      end
      if (w_cap) r_rbuf <= w_assembled;
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, reset/wrap sequences and randomized
// accesses checked against a byte-array memory model.
module tb_mem_access_ctrl;
   localparam int XLEN   = 32;
   localparam int ADDR_W = 32;
   localparam int RD_LAT = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_access_ctrl_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) ifc ();
   mem_access_ctrl_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) ifc2 ();

   mem_access_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .ALIGN_CHECK(1))
      u_dut (.clk(clk), .rst(rst), .bus(ifc.slave));
   mem_access_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .ALIGN_CHECK(0))
      u_dut_na (.clk(clk), .rst(rst), .bus(ifc2.slave));

   // Byte memory with RD_LAT-cycle read pipeline
   logic [7:0]  ram_mem [0:4095] = '{default: 8'h00};
   logic [11:0] rp [0:RD_LAT-1]  = '{default: 12'h000};
   always @(posedge clk) begin
      if (ifc.ram_we_o) ram_mem[ifc.ram_addr_o[11:0]] <= ifc.ram_wdata_o;
      rp[0] <= ifc.ram_addr_o[11:0];
      for (int i = 1; i < RD_LAT; i++) rp[i] <= rp[i-1];
   end
   assign ifc.ram_rdata_i  = ram_mem[rp[RD_LAT-1]];
   assign ifc2.ram_rdata_i = 8'h00;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] last_rdata = 32'h0;
   logic [7:0]  ref_mem [0:4095];

   typedef struct {
      logic        we;
      logic [1:0]  sel;
      logic        sign;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_done;
   } vec_t;
   vec_t vecs [14];

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [79:0] obs();
      return {4'h0, ifc.busy_o, ifc.done_o, ifc.err_o, ifc.ram_we_o,
              ifc.ram_addr_o, ifc.ram_wdata_o, ifc.rdata_o};
   endfunction

   function automatic logic [79:0] obs2();
      return {4'h0, ifc2.busy_o, ifc2.done_o, ifc2.err_o, ifc2.ram_we_o,
              ifc2.ram_addr_o, ifc2.ram_wdata_o, ifc2.rdata_o};
   endfunction

   // One full transaction: request in cycle 0, then per-cycle check of bus and status up to done.
   task automatic do_op(input logic we, input logic [1:0] sel, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_done,
                        input string nm);
      int          n;
      logic [31:0] ea;
      logic [7:0]  eb;
      logic        ewe;
      n = 1 << sel;
      @(negedge clk);
      ifc.req_i = 1'b1; ifc.we_i = we; ifc.sel_i = sel; ifc.sign_i = sign;
      ifc.addr_i = addr; ifc.wdata_i = wdata;
      #1;
      chk({nm, " c0"}, obs(), {4'h0, 4'b1000, 32'h0, 8'h00, last_rdata});
      for (int c = 1; c <= exp_done; c++) begin
         @(negedge clk);
         ea = 32'h0; eb = 8'h00; ewe = 1'b0;
         if (!exp_err && c <= n) begin
            ea  = addr + 32'(c - 1);
            ewe = we;
            eb  = we ? 8'(wdata >> (8 * (c - 1))) : 8'h00;
         end
         chk($sformatf("%s c%0d", nm, c), obs(),
             {4'h0, (c < exp_done), (c == exp_done), (exp_err && c == exp_done), ewe,
              ea, eb, (c < exp_done) ? last_rdata : exp_rd});
         // scrambled inputs after accept; a request in the done cycle must be ignored
         ifc.req_i   = (c == exp_done);
         ifc.we_i    = 1'($urandom);
         ifc.sel_i   = 2'($urandom);
         ifc.sign_i  = 1'($urandom);
         ifc.addr_i  = $urandom;
         ifc.wdata_i = $urandom;
      end
      last_rdata = exp_rd;
   endtask

   task automatic go_idle();
      @(negedge clk);
      ifc.req_i = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, n_bad=%0d expected 0", n_bad);
      $fatal(1);
   end

   initial begin
      logic        we, sign, ill;
      logic [1:0]  sel;
      logic [31:0] addr, wdata, v, msk, expv;
      int          n, dn;

      ifc.req_i = 0; ifc.we_i = 0; ifc.sel_i = 0; ifc.sign_i = 0; ifc.addr_i = 0; ifc.wdata_i = 0;
      ifc2.req_i = 0; ifc2.we_i = 0; ifc2.sel_i = 0; ifc2.sign_i = 0; ifc2.addr_i = 0; ifc2.wdata_i = 0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;

      vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h00000000, 1'b0, 5};
      vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 7};
      vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h200, 32'h00000080, 32'hDEADBEEF, 1'b0, 2};
      vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h200, 32'h0,        32'hFFFFFF80, 1'b0, 4};
      vecs[4]  = '{1'b0, 2'd0, 1'b0, 32'h200, 32'h0,        32'h00000080, 1'b0, 4};
      vecs[5]  = '{1'b1, 2'd1, 1'b0, 32'h300, 32'h00009234, 32'h00000080, 1'b0, 3};
      vecs[6]  = '{1'b0, 2'd1, 1'b1, 32'h300, 32'h0,        32'hFFFF9234, 1'b0, 5};
      vecs[7]  = '{1'b0, 2'd1, 1'b0, 32'h300, 32'h0,        32'h00009234, 1'b0, 5};
      vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h202, 32'h0,        32'h00009234, 1'b1, 1};
      vecs[9]  = '{1'b0, 2'd3, 1'b0, 32'h300, 32'h0,        32'h00009234, 1'b1, 1};
      vecs[10] = '{1'b1, 2'd1, 1'b0, 32'h301, 32'h0000ABCD, 32'h00009234, 1'b1, 1};
      vecs[11] = '{1'b0, 2'd0, 1'b1, 32'h301, 32'h0,        32'hFFFFFF92, 1'b0, 4};
      vecs[12] = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        32'h000000DE, 1'b0, 4};
      vecs[13] = '{1'b0, 2'd1, 1'b1, 32'h102, 32'h0,        32'hFFFFDEAD, 1'b0, 5};

      // reset state, including busy held low while a request is presented
      #1 rst = 1'b0;
      #11;
      chk("reset outputs", obs(), 80'h0);
      ifc.req_i = 1'b1;
      #1;
      chk("reset busy gated", obs(), 80'h0);
      ifc.req_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("after reset", obs(), 80'h0);

      for (int i = 0; i < 14; i++)
         do_op(vecs[i].we, vecs[i].sel, vecs[i].sign, vecs[i].addr, vecs[i].wdata,
               vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_done, $sformatf("vec%0d", i));
      go_idle();

      // reset in the middle of a word store: write enable drops without a clock edge
      @(negedge clk);
      ifc.req_i = 1'b1; ifc.we_i = 1'b1; ifc.sel_i = 2'd2; ifc.sign_i = 1'b0;
      ifc.addr_i = 32'h500; ifc.wdata_i = 32'h11223344;
      @(negedge clk);
      ifc.req_i = 1'b0;
      @(negedge clk);
      chk("rst_store c2", obs(), {4'h0, 4'b1001, 32'h501, 8'h33, last_rdata});
      #2 rst = 1'b0;
      ifc.req_i = 1'b1;
      #1;
      chk("rst_store asserted", obs(), 80'h0);
      @(negedge clk);
      rst = 1'b1;
      ifc.req_i = 1'b0;
      last_rdata = 32'h0;
      #1;
      chk("rst_store released", obs(), 80'h0);
      do_op(1'b1, 2'd2, 1'b0, 32'h600, 32'hA5C30F96, 32'h0, 1'b0, 5, "post_rst st");
      do_op(1'b0, 2'd2, 1'b0, 32'h600, 32'h0, 32'hA5C30F96, 1'b0, 7, "post_rst ld");
      do_op(1'b0, 2'd0, 1'b0, 32'h500, 32'h0, 32'h00000044, 1'b0, 4, "rst byte0");
      do_op(1'b0, 2'd0, 1'b0, 32'h501, 32'h0, 32'h00000000, 1'b0, 4, "rst byte1");
      go_idle();

      // reset while load reads are in flight: returned bytes must be discarded
      @(negedge clk);
      ifc.req_i = 1'b1; ifc.we_i = 1'b0; ifc.sel_i = 2'd2; ifc.addr_i = 32'h100;
      @(negedge clk);
      ifc.req_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_load asserted", obs(), 80'h0);
      @(negedge clk);
      rst = 1'b1;
      last_rdata = 32'h0;
      @(negedge clk);
      chk("rst_load idle", obs(), 80'h0);
      do_op(1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 32'h000000EF, 1'b0, 4, "rst_load next");
      go_idle();

      // misalignment permitted: word store wrapping past the top of the address space
      @(negedge clk);
      ifc2.req_i = 1'b1; ifc2.we_i = 1'b1; ifc2.sel_i = 2'd2; ifc2.sign_i = 1'b0;
      ifc2.addr_i = 32'hFFFFFFFE; ifc2.wdata_i = 32'hCAFEF00D;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         ifc2.req_i = 1'b0;
         if (c <= 4)
            chk($sformatf("wrap c%0d", c), obs2(),
                {4'h0, 4'b1001, 32'hFFFFFFFE + 32'(c - 1), 8'(32'hCAFEF00D >> (8 * (c - 1))), 32'h0});
         else
            chk("wrap done", obs2(), {4'h0, 4'b0100, 32'h0, 8'h00, 32'h0});
      end

      // randomized accesses against the byte-array model
      for (int t = 0; t < 60; t++) begin
         we    = 1'($urandom);
         sel   = 2'($urandom_range(0, 3));
         sign  = 1'($urandom);
         addr  = 32'h400 + 32'($urandom_range(0, 15));
         wdata = $urandom;
         n     = 1 << sel;
         ill   = (sel == 2'd3) || ((addr % n) != 0);
         dn    = ill ? 1 : (we ? n + 1 : n + RD_LAT + 1);
         expv  = last_rdata;
         if (!ill && we)
            for (int k = 0; k < n; k++) ref_mem[12'(addr + k)] = wdata[8*k +: 8];
         if (!ill && !we) begin
            v = 32'h0;
            for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[12'(addr + k)];
            if (n < 4) begin
               msk = (32'h1 << (8 * n)) - 32'h1;
               if (sign && v[8*n-1]) v = v | ~msk;
            end
            expv = v;
         end
         do_op(we, sel, sign, addr, wdata, expv, ill, dn, $sformatf("rnd%0d", t));
      end
      go_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
